algo_refresh_sched: RTL and testbench

- Refresh-request scheduler upstream of the multiport DRAM-backed algorithm (3r1w family).
- Paces the top-level `refr` input at REFFREQ, or REFFREQ+0.5 when REFFRHF=1, average cycles per refresh.
- Banks refreshes that are postponed while the host asserts `hold`, then drains them.
- Walks the refresh bank/row address that the algorithm's physical refresh ports (refrB/bankB) consume.

---
 rtl/algo_refresh_sched.sv | 179 +++++++++++++++++
 tb/tb_algo_refresh_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/algo_refresh_sched.sv
// rtl/algo_refresh_sched.sv - refresh-request pacer with postponement credit and bank/row walk
// Optional macro REFR_STAT_EN: builds the saturating 16-bit issued-refresh counter on ref_cnt.
module algo_refresh_sched #(
  parameter int REFFREQ = 6,
  parameter int REFFRHF = 0,
  parameter int NUMRROW = 256,
  parameter int BITRROW = 8,
  parameter int NUMRBNK = 1,
  parameter int BITRBNK = 1,
  parameter int MAXPEND = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               hold,
  output logic               refr,
  output logic [BITRBNK-1:0] ref_bank,
  output logic [BITRROW-1:0] ref_row,
  output logic               ref_sweep,
  output logic               ref_ovf,
  output logic [15:0]        ref_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  // cnt is 9 bits so REFFREQ=255 with the half-cycle extension still fits
  localparam logic [8:0]         PERIOD_M1 = 9'(REFFREQ - 1);
  localparam logic               HALF_EN   = (REFFRHF != 0);
  localparam logic [3:0]         MAX_CRED  = 4'(MAXPEND);
  localparam logic [BITRBNK-1:0] LAST_BANK = BITRBNK'(NUMRBNK - 1);
  localparam logic [BITRROW-1:0] LAST_ROW  = BITRROW'(NUMRROW - 1);

  state_t             state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [3:0]         credit_q, credit_d;
  logic               half_q, half_d;
  logic [BITRBNK-1:0] bank_ptr_q, bank_ptr_d;
  logic [BITRROW-1:0] row_ptr_q, row_ptr_d;
  logic               refr_q, refr_d;
  logic [BITRBNK-1:0] ref_bank_q, ref_bank_d;
  logic [BITRROW-1:0] ref_row_q, ref_row_d;
  logic               ref_sweep_q, ref_sweep_d;
  logic               ref_ovf_q, ref_ovf_d;

  logic [8:0] period_m1;
  logic       run_act;
  logic       tick;
  logic       issue;

  // Interval, credit and address-walk next-state; a tick that cannot be issued is banked as credit
  always_comb begin
    period_m1   = PERIOD_M1 + {8'd0, HALF_EN & half_q};
    run_act     = (state_q == RUN) && ready;
    tick        = run_act && (cnt_q == period_m1);
    issue       = run_act && !hold && ((credit_q != 4'd0) || tick);

    state_d     = state_q;
    cnt_d       = cnt_q;
    credit_d    = credit_q;
    half_d      = half_q;
    bank_ptr_d  = bank_ptr_q;
    row_ptr_d   = row_ptr_q;
    refr_d      = 1'b0;
    ref_bank_d  = ref_bank_q;
    ref_row_d   = ref_row_q;
    ref_sweep_d = 1'b0;
    ref_ovf_d   = ref_ovf_q;

    case (state_q)
      IDLE: begin
        cnt_d    = 9'd0;
        credit_d = 4'd0;
        half_d   = 1'b0;
        if (ready) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!ready) begin
          // Losing ready abandons banked credit and restarts the walk; ref_ovf stays sticky
          state_d    = IDLE;
          cnt_d      = 9'd0;
          credit_d   = 4'd0;
          half_d     = 1'b0;
          bank_ptr_d = '0;
          row_ptr_d  = '0;
        end else begin
          cnt_d = tick ? 9'd0 : (cnt_q + 9'd1);
          if (tick && HALF_EN) begin
            half_d = ~half_q;
          end
          if (tick && !issue) begin
            if (credit_q == MAX_CRED) begin
              ref_ovf_d = 1'b1;
            end else begin
              credit_d = credit_q + 4'd1;
            end
          end else if (!tick && issue) begin
            credit_d = credit_q - 4'd1;
          end
          if (issue) begin
            refr_d      = 1'b1;
            ref_bank_d  = bank_ptr_q;
            ref_row_d   = row_ptr_q;
            ref_sweep_d = (bank_ptr_q == LAST_BANK) && (row_ptr_q == LAST_ROW);
            if (bank_ptr_q == LAST_BANK) begin
              bank_ptr_d = '0;
              row_ptr_d  = (row_ptr_q == LAST_ROW) ? '0 : (row_ptr_q + BITRROW'(1));
            end else begin
              bank_ptr_d = bank_ptr_q + BITRBNK'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      credit_q    <= 4'd0;
      half_q      <= 1'b0;
      bank_ptr_q  <= '0;
      row_ptr_q   <= '0;
      refr_q      <= 1'b0;
      ref_bank_q  <= '0;
      ref_row_q   <= '0;
      ref_sweep_q <= 1'b0;
      ref_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      credit_q    <= credit_d;
      half_q      <= half_d;
      bank_ptr_q  <= bank_ptr_d;
      row_ptr_q   <= row_ptr_d;
      refr_q      <= refr_d;
      ref_bank_q  <= ref_bank_d;
      ref_row_q   <= ref_row_d;
      ref_sweep_q <= ref_sweep_d;
      ref_ovf_q   <= ref_ovf_d;
    end
  end

  assign refr      = refr_q;
  assign ref_bank  = ref_bank_q;
  assign ref_row   = ref_row_q;
  assign ref_sweep = ref_sweep_q;
  assign ref_ovf   = ref_ovf_q;

`ifdef REFR_STAT_EN
  logic [15:0] stat_cnt_q, stat_cnt_d;

  // Count cycles with refr high, saturating; only rst clears it
  always_comb begin
    stat_cnt_d = stat_cnt_q;
    if (refr_q && (stat_cnt_q != 16'hFFFF)) begin
      stat_cnt_d = stat_cnt_q + 16'd1;
    end
  end

  // Statistics register
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt_q <= 16'd0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign ref_cnt = stat_cnt_q;
`else
  assign ref_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_algo_refresh_sched.sv
// tb/tb_algo_refresh_sched.sv - scoreboard bench for algo_refresh_sched
module tb_algo_refresh_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_a, hold_a, ready_b, hold_b;
  logic        refr_a, refr_b;
  logic [0:0]  bank_a, bank_b;
  logic [1:0]  row_a, row_b;
  logic        sweep_a, sweep_b, ovf_a, ovf_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  algo_refresh_sched #(
    .REFFREQ(6), .REFFRHF(0), .NUMRROW(4), .BITRROW(2),
    .NUMRBNK(2), .BITRBNK(1), .MAXPEND(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .hold(hold_a),
    .refr(refr_a), .ref_bank(bank_a), .ref_row(row_a),
    .ref_sweep(sweep_a), .ref_ovf(ovf_a), .ref_cnt(cnt_a)
  );

  algo_refresh_sched #(
    .REFFREQ(6), .REFFRHF(1), .NUMRROW(4), .BITRROW(2),
    .NUMRBNK(1), .BITRBNK(1), .MAXPEND(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .hold(hold_b),
    .refr(refr_b), .ref_bank(bank_b), .ref_row(row_b),
    .ref_sweep(sweep_b), .ref_ovf(ovf_b), .ref_cnt(cnt_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int b;
    int r;
    int s;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_pulse(input string name, input exp_t e, input int c, input int b,
                             input int r, input int s);
    n_checks++;
    if (e.c == c && e.b == b && e.r == r && e.s == s) n_pass++;
    else $display("FAIL %s: got cycle=%0d bank=%0d row=%0d sweep=%0d required cycle=%0d bank=%0d row=%0d sweep=%0d",
                  name, c, b, r, s, e.c, e.b, e.r, e.s);
  endtask

  task automatic push_a(input int c, input int b, input int r, input int s);
    exp_t e;
    e.c = c; e.b = b; e.r = r; e.s = s;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input int b, input int r, input int s);
    exp_t e;
    e.c = c; e.b = b; e.r = r; e.s = s;
    q_b.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor for instance A: every refr pulse must match the head of its queue
  always @(negedge clk) begin
    if (!rst && refr_a) begin
      if (q_a.size() == 0) begin
        n_checks++;
        $display("FAIL refr_a_unexpected: got pulse at cycle %0d required none", cyc);
      end else begin
        check_pulse("refr_a", q_a.pop_front(), cyc, int'(bank_a), int'(row_a), int'(sweep_a));
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    if (!rst && refr_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        $display("FAIL refr_b_unexpected: got pulse at cycle %0d required none", cyc);
      end else begin
        check_pulse("refr_b", q_b.pop_front(), cyc, int'(bank_b), int'(row_b), int'(sweep_b));
      end
    end
  end

  int base;
  int hf_off[8] = '{0, 7, 13, 20, 26, 33, 39, 46};

  initial begin
    rst = 1'b1; ready_a = 1'b0; hold_a = 1'b0; ready_b = 1'b0; hold_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_refr", int'(refr_a), 0);
    check("rst_bank", int'(bank_a), 0);
    check("rst_row", int'(row_a), 0);
    check("rst_sweep", int'(sweep_a), 0);
    check("rst_ovf", int'(ovf_a), 0);
    check("rst_cnt", int'(cnt_a), 0);
    check("rst_refr_b", int'(refr_b), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_refr", int'(refr_a), 0);

    // Free-running pacing and bank-first address walk; B checks 6/7 alternation
    base = cyc;
    ready_a = 1'b1;
    ready_b = 1'b1;
    for (int k = 0; k < 9; k++) push_a(base + 7 + 6 * k, k % 2, (k / 2) % 4, (k == 7) ? 1 : 0);
    for (int k = 0; k < 8; k++) push_b(base + 7 + hf_off[k], 0, k % 4, (k % 4 == 3) ? 1 : 0);
    wait_until(base + 54);
    ready_b = 1'b0;
    wait_until(base + 57);
    check("free_ovf", int'(ovf_a), 0);
    ready_a = 1'b0;
    repeat (3) @(negedge clk);

    // Hold 20 cycles: three banked ticks drain back to back
    base = cyc;
    ready_a = 1'b1;
    hold_a = 1'b1;
    push_a(base + 21, 0, 0, 0);
    push_a(base + 22, 1, 0, 0);
    push_a(base + 23, 0, 1, 0);
    push_a(base + 25, 1, 1, 0);
    push_a(base + 31, 0, 2, 0);
    wait_until(base + 20);
    hold_a = 1'b0;
    wait_until(base + 33);
    check("hold20_ovf", int'(ovf_a), 0);
    ready_a = 1'b0;
    repeat (3) @(negedge clk);

    // Hold 31 cycles: credit saturates at 4 and ref_ovf sticks
    base = cyc;
    ready_a = 1'b1;
    hold_a = 1'b1;
    push_a(base + 32, 0, 0, 0);
    push_a(base + 33, 1, 0, 0);
    push_a(base + 34, 0, 1, 0);
    push_a(base + 35, 1, 1, 0);
    push_a(base + 37, 0, 2, 0);
    push_a(base + 43, 1, 2, 0);
    wait_until(base + 30);
    check("hold31_ovf_before", int'(ovf_a), 0);
    wait_until(base + 31);
    check("hold31_ovf_set", int'(ovf_a), 1);
    hold_a = 1'b0;
    wait_until(base + 45);
    check("hold31_ovf_sticky", int'(ovf_a), 1);
    ready_a = 1'b0;
    repeat (3) @(negedge clk);

    // Drop ready with two credits banked: no pulses, then a fresh interval from (0,0)
    base = cyc;
    ready_a = 1'b1;
    hold_a = 1'b1;
    wait_until(base + 13);
    ready_a = 1'b0;
    wait_until(base + 20);
`ifdef REFR_STAT_EN
    check("stat_after_drop", int'(cnt_a), 20);
`endif
    hold_a = 1'b0;
    base = cyc;
    ready_a = 1'b1;
    push_a(base + 7, 0, 0, 0);
    wait_until(base + 10);
`ifdef REFR_STAT_EN
    check("stat_after_restart", int'(cnt_a), 21);
`else
    check("stat_tied_zero", int'(cnt_a), 0);
`endif
    check("ovf_survives_drop", int'(ovf_a), 1);
    check("hf_ovf", int'(ovf_b), 0);
    ready_a = 1'b0;
    repeat (2) @(negedge clk);

    check("queue_a_left", q_a.size(), 0);
    check("queue_b_left", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
